// File: rtl/fft_frame_source_pkg.sv
// Shared definitions for the FFT frame source: default geometry, run modes and FSM states.
package fft_frame_source_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_POINTS = 16;

   typedef enum logic [1:0] {
      MODE_SINGLE = 2'd0,
      MODE_NFRAME = 2'd1,
      MODE_CONT   = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_GAP
   } state_e;

endpackage

// File: rtl/fft_src_ram.sv
// Frame buffer: POINTS x (2*DATA_W) dual-port RAM, registered read, read-before-write.
module fft_src_ram #(
   parameter int DATA_W = 16,
   parameter int POINTS = 16,
   parameter int ADDR_W = $clog2(POINTS)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [2*DATA_W-1:0]   wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [2*DATA_W-1:0]   rd_data
);

   logic [2*DATA_W-1:0] mem [POINTS];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Only the read register is reset so the sample outputs clear with rstn.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)      rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fft_frame_source.sv
// Replays a buffered frame on the FFT input bus in natural or bit-reversed order.
module fft_frame_source
   import fft_frame_source_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int POINTS = DEF_POINTS,
   parameter int ADDR_W = $clog2(POINTS),
   parameter int CNT_W  = 16,
   parameter int GAP_W  = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_re,
   input  logic [DATA_W-1:0] wr_im,
   input  logic              start,
   input  logic              stop,
   input  logic [1:0]        mode,
   input  logic [CNT_W-1:0]  frame_cnt,
   input  logic [GAP_W-1:0]  gap,
   input  logic              bit_rev,
   output logic              do_en,
   output logic [DATA_W-1:0] do_re,
   output logic [DATA_W-1:0] do_im,
   output logic              do_sof,
   output logic              do_eof,
   output logic              busy,
   output logic              done
);

   state_e              state;
   mode_e               mode_l;
   logic [ADDR_W-1:0]   addr_cnt;
   logic [ADDR_W-1:0]   rev_addr;
   logic [ADDR_W-1:0]   rd_addr;
   logic [GAP_W-1:0]    gap_l;
   logic [GAP_W-1:0]    gap_cnt;
   logic [CNT_W-1:0]    frames_left;
   logic                bit_rev_l;
   logic                stop_flag;
   logic                stop_pend;
   logic                run;
   logic                last;
   logic                more;
   logic [2*DATA_W-1:0] rd_data;

   always_comb begin
      rev_addr = '0;
      for (int unsigned i = 0; i < ADDR_W; i++) rev_addr[i] = addr_cnt[ADDR_W-1-i];
   end

   assign run       = (state == ST_RUN);
   assign last      = &addr_cnt;
   assign rd_addr   = bit_rev_l ? rev_addr : addr_cnt;
   assign stop_pend = stop_flag | stop;
   assign more      = !stop_pend &&
                      ((mode_l == MODE_CONT) ||
                       (mode_l == MODE_NFRAME && frames_left > CNT_W'(1)));

   fft_src_ram #(
      .DATA_W (DATA_W),
      .POINTS (POINTS),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data ({wr_re, wr_im}),
      .rd_en   (run),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign do_re = rd_data[2*DATA_W-1:DATA_W];
   assign do_im = rd_data[DATA_W-1:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         mode_l      <= MODE_SINGLE;
         addr_cnt    <= '0;
         gap_l       <= '0;
         gap_cnt     <= '0;
         frames_left <= '0;
         bit_rev_l   <= 1'b0;
         stop_flag   <= 1'b0;
         do_en       <= 1'b0;
         do_sof      <= 1'b0;
         do_eof      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         // Frame flags track the read issued this cycle; RAM data lands alongside them.
         do_en  <= run;
         do_sof <= run && (addr_cnt == '0);
         do_eof <= run && last;
         done   <= 1'b0;
         if (stop) stop_flag <= 1'b1;

         case (state)
            ST_IDLE: begin
               busy <= 1'b0;
               if (start && !busy) begin
                  state       <= ST_RUN;
                  busy        <= 1'b1;
                  addr_cnt    <= '0;
                  stop_flag   <= 1'b0;
                  mode_l      <= mode_e'(mode);
                  gap_l       <= gap;
                  bit_rev_l   <= bit_rev;
                  frames_left <= (frame_cnt == '0) ? CNT_W'(1) : frame_cnt;
               end
            end
            ST_RUN: begin
               busy     <= 1'b1;
               addr_cnt <= addr_cnt + 1'b1;
               if (last) begin
                  if (more) begin
                     frames_left <= frames_left - 1'b1;
                     if (gap_l != '0) begin
                        state   <= ST_GAP;
                        gap_cnt <= gap_l - 1'b1;
                     end
                  end else begin
                     state <= ST_IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_GAP: begin
               busy <= 1'b1;
               // A stop here ends the run at once; the last frame already went out whole.
               if (stop_pend) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (gap_cnt == '0) begin
                  state <= ST_RUN;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_frame_source.sv
// Directed, table-driven bench for fft_frame_source with a cycle-timeline reference model.
module tb_fft_frame_source;

   localparam int DW  = 16;
   localparam int PTS = 16;
   localparam int AW  = 4;
   localparam int CW  = 16;
   localparam int GW  = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_re = '0;
   logic [DW-1:0] wr_im = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [1:0]    mode = '0;
   logic [CW-1:0] frame_cnt = '0;
   logic [GW-1:0] gap = '0;
   logic          bit_rev = 1'b0;
   logic          do_en, do_sof, do_eof, busy, done;
   logic [DW-1:0] do_re, do_im;

   fft_frame_source #(
      .DATA_W (DW),
      .POINTS (PTS),
      .CNT_W  (CW),
      .GAP_W  (GW)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_re     (wr_re),
      .wr_im     (wr_im),
      .start     (start),
      .stop      (stop),
      .mode      (mode),
      .frame_cnt (frame_cnt),
      .gap       (gap),
      .bit_rev   (bit_rev),
      .do_en     (do_en),
      .do_re     (do_re),
      .do_im     (do_im),
      .do_sof    (do_sof),
      .do_eof    (do_eof),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    mode;
      logic [CW-1:0] fc;
      logic [GW-1:0] gap;
      logic          br;
      int            frames;
      int            stop_k;
   } vec_t;

   vec_t          vecs[9];
   logic [DW-1:0] exp_re[PTS];
   logic [DW-1:0] exp_im[PTS];
   int            checks = 0;
   int            errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic int rev(input int x);
      int r;
      r = 0;
      for (int b = 0; b < AW; b++) if ((x & (1 << b)) != 0) r |= 1 << (AW - 1 - b);
      return r;
   endfunction

   task automatic load_buf();
      for (int i = 0; i < PTS; i++) begin
         @(negedge clk);
         wr_en   = 1'b1;
         wr_addr = AW'(i);
         wr_re   = exp_re[i];
         wr_im   = exp_im[i];
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // k counts negedges from the one just after the start edge E0 (k = 0).
   task automatic run_vec(input int id, input vec_t v);
      int         period, last_off, off, idx;
      logic       ev;
      logic [4:0] ectl;
      @(negedge clk);
      mode = v.mode; frame_cnt = v.fc; gap = v.gap; bit_rev = v.br; start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      mode      = (v.mode == 2'd2) ? 2'd0 : 2'd2;
      frame_cnt = 16'd9;
      gap       = 8'd1;
      bit_rev   = ~v.br;
      period    = PTS + int'(v.gap);
      last_off  = (v.frames - 1) * period + PTS - 1;
      for (int k = 0; k <= last_off + 3; k++) begin
         if (k > 0) @(negedge clk);
         start = (k == 5) || (k == last_off + 1);
         stop  = (v.stop_k != 0) && (k == v.stop_k);
         off   = k - 1;
         ev    = (off >= 0) && (off / period < v.frames) && (off % period < PTS);
         ectl  = {ev, ev && (off % period == 0), ev && (off % period == PTS - 1),
                  ev && (off == last_off), off <= last_off};
         check($sformatf("v%0d k%0d en/sof/eof/done/busy", id, k),
               64'({do_en, do_sof, do_eof, done, busy}), 64'(ectl));
         if (ev) begin
            idx = v.br ? rev(off % period) : off % period;
            check($sformatf("v%0d k%0d data", id, k), 64'({do_re, do_im}),
                  64'({exp_re[idx], exp_im[idx]}));
         end
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      int init_re[PTS] = '{5000, 500, 500, 500, 0, 0, 0, 0, 100, 200, 300, 400, 500, 600, 700, 800};
      for (int i = 0; i < PTS; i++) begin
         exp_re[i] = DW'(init_re[i]);
         exp_im[i] = DW'(i * 7 + 3);
      end
      //           mode   fc      gap   br    frames stop_k
      vecs[0] = '{2'd0, 16'd0, 8'd0, 1'b0, 1, 0};
      vecs[1] = '{2'd0, 16'd0, 8'd0, 1'b1, 1, 0};
      vecs[2] = '{2'd1, 16'd3, 8'd0, 1'b0, 3, 0};
      vecs[3] = '{2'd1, 16'd2, 8'd5, 1'b0, 2, 0};
      vecs[4] = '{2'd1, 16'd0, 8'd0, 1'b0, 1, 0};
      vecs[5] = '{2'd3, 16'd5, 8'd2, 1'b0, 1, 0};
      vecs[6] = '{2'd2, 16'd0, 8'd0, 1'b0, 2, 24};
      vecs[7] = '{2'd2, 16'd0, 8'd3, 1'b1, 1, 8};
      vecs[8] = '{2'd1, 16'd2, 8'd2, 1'b1, 2, 0};

      #12;
      check("reset ctl", 64'({do_en, do_sof, do_eof, done, busy}), 64'd0);
      check("reset data", 64'({do_re, do_im}), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      load_buf();

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Write to address 3 in the cycle it is read: old value now, new value next frame.
      @(negedge clk);
      mode = 2'd1; frame_cnt = 16'd2; gap = 8'd0; bit_rev = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd3; wr_re = 16'h1234; wr_im = 16'h4321;
      @(negedge clk);
      wr_en = 1'b0;
      check("rbw old sample", 64'({do_en, do_re, do_im}), 64'({1'b1, 16'd500, 16'd24}));
      repeat (16) @(negedge clk);
      check("rbw new sample", 64'({do_en, do_re, do_im}), 64'({1'b1, 16'h1234, 16'h4321}));
      repeat (14) @(negedge clk);
      check("rbw run over", 64'({do_en, busy}), 64'd0);
      exp_re[3] = 16'h1234;
      exp_im[3] = 16'h4321;

      // Asynchronous reset in the middle of a continuous run.
      @(negedge clk);
      mode = 2'd2; gap = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("pre-reset sample", 64'({do_en, busy, do_re}), 64'({1'b1, 1'b1, 16'd200}));
      #2 rstn = 1'b0;
      #1;
      check("mid-run reset ctl", 64'({do_en, do_sof, do_eof, done, busy}), 64'd0);
      check("mid-run reset data", 64'({do_re, do_im}), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("post-reset idle %0d", k), 64'({do_en, done, busy}), 64'd0);
      end
      load_buf();
      run_vec(99, vecs[2]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
